// File: rtl/div32_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero short-circuits to DONE with an all-ones quotient and rem = A.
module div32_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             zero
);

   localparam int unsigned CW = 6;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] prem;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             qbit;
   logic [WIDTH-1:0] prem_nxt;
   logic [WIDTH-1:0] dvd_nxt;

   // One restoring step; the extra bit of diff is the borrow of the trial subtract.
   always_comb begin
      shifted  = {prem, dvd[WIDTH-1]};
      diff     = shifted - {1'b0, dvs};
      qbit     = ~diff[WIDTH];
      prem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      dvd_nxt  = {dvd[WIDTH-2:0], qbit};
   end

   // Dividend register doubles as the quotient shift register during RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         prem     <= '0;
         quot     <= '0;
         rem      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         zero     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (B == '0) begin
                     quot     <= '1;
                     rem      <= A;
                     div_zero <= 1'b1;
                     zero     <= 1'b0;
                     done     <= 1'b1;
                     state    <= DONE;
                  end else begin
                     dvd   <= A;
                     dvs   <= B;
                     prem  <= '0;
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               prem <= prem_nxt;
               dvd  <= dvd_nxt;
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  quot     <= dvd_nxt;
                  rem      <= prem_nxt;
                  zero     <= (dvd_nxt == '0);
                  div_zero <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: expected results queued at start, checked at done.
module tb_div32_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] quot;
   logic [31:0] rem;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic        zero;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
      logic        dz;
      int          lat;
      int          nbusy;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] last_q   = 32'd0;
   logic [31:0] last_r   = 32'd0;

   div32_seq #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .A        (A),
      .B        (B),
      .quot     (quot),
      .rem      (rem),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one division; optionally pulse a second start at RUN cycle inj_cyc.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ez, input logic edz, input int inj_cyc);
      exp_t e;
      exp_t got;
      int   cyc;
      int   nb;
      e.q = eq; e.r = er; e.z = ez; e.dz = edz;
      e.lat   = (b == 32'd0) ? 0 : 32;
      e.nbusy = (b == 32'd0) ? 0 : 32;
      sb.push_back(e);
      start = 1'b1; A = a; B = b;
      step();
      start = 1'b0; A = ~a; B = 32'd3;
      cyc = 0;
      nb  = 0;
      while (!done && cyc < 40) begin
         if (busy) nb++;
         if (cyc == 5) begin
            chk("hold_quot_run", quot, last_q);
            chk("hold_rem_run", rem, last_r);
         end
         if (cyc == inj_cyc) begin
            start = 1'b1; A = 32'd9; B = 32'd2;
         end else begin
            start = 1'b0;
         end
         step();
         cyc++;
      end
      start = 1'b0;
      got = sb.pop_front();
      chk("latency", 32'(cyc), 32'(got.lat));
      chk("busy_cycles", 32'(nb), 32'(got.nbusy));
      chk("done", {31'd0, done}, 32'd1);
      chk("busy_in_done", {31'd0, busy}, 32'd0);
      chk("quot", quot, got.q);
      chk("rem", rem, got.r);
      chk("zero", {31'd0, zero}, {31'd0, got.z});
      chk("div_zero", {31'd0, div_zero}, {31'd0, got.dz});
      step();
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("hold_quot_idle", quot, got.q);
      chk("hold_rem_idle", rem, got.r);
      last_q = got.q;
      last_r = got.r;
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          cyc;
      int          seen_done;

      // Reset with start asserted: reset wins.
      reset = 1'b1; start = 1'b1; A = 32'd100; B = 32'd7;
      step();
      step();
      chk("rst_quot", quot, 32'd0);
      chk("rst_rem", rem, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd1);
      reset = 1'b0; start = 1'b0;
      step();

      run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, -1);
      run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, -1);
      run_op(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, -1);
      run_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b1, 1'b0, -1);
      run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, -1);
      run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 10);
      // No stray operation may follow the ignored start.
      step();
      step();
      chk("no_queued_start", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if (rb == 32'd0) rb = 32'd13;
         run_op(ra, rb, ra / rb, ra % rb, (ra / rb) == 32'd0, 1'b0, -1);
      end

      // Abort at RUN cycle 15, then start immediately after reset releases.
      start = 1'b1; A = 32'd100; B = 32'd7;
      step();
      start = 1'b0;
      for (int i = 0; i < 15; i++) step();
      chk("abort_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_busy_clr", {31'd0, busy}, 32'd0);
      chk("abort_quot", quot, 32'd0);
      chk("abort_rem", rem, 32'd0);
      chk("abort_zero", {31'd0, zero}, 32'd1);
      chk("abort_div_zero", {31'd0, div_zero}, 32'd0);
      last_q = 32'd0;
      last_r = 32'd0;
      run_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0, -1);

      // Nothing further may complete once idle.
      seen_done = 0;
      cyc = 0;
      while (cyc < 40) begin
         if (done) seen_done++;
         step();
         cyc++;
      end
      chk("idle_no_done", 32'(seen_done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
